seg7_sum_scanner: RTL and testbench

SEG7_SUM_SCANNER -- requirements
Module: seg7_sum_scanner

---
 rtl/seg7_sum_scanner.sv | 72 +++++++
 tb/tb_seg7_sum_scanner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_sum_scanner.sv
// seg7_sum_scanner: captures {Cout,Sum} on a synchronized Load edge and scans it onto an 8-digit active-low 7-segment display.
module seg7_sum_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        Clk,
  input  logic        Rs,
  input  logic [15:0] Sum,
  input  logic        Cout,
  input  logic        Load,
  output logic [7:0]  AN,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic        Valid
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  logic [16:0]   disp_q, disp_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          rise, wrap, lit;
  logic [3:0]    nib;
  always_comb begin
    sync_d  = {sync_q[0], Load};
    prev_d  = sync_q[1];
    rise    = sync_q[1] & ~prev_q;
    disp_d  = rise ? {Cout, Sum} : disp_q;
    valid_d = valid_q | rise;
    wrap    = cnt_q == CW'(REFRESH_DIV - 1);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = wrap ? idx_q + 3'd1 : idx_q;
    nib     = disp_q[{idx_q[1:0], 2'b00} +: 4];
    // digit 4 is the carry slot and lights only when the captured carry is set
    lit     = valid_q & ((idx_q < 3'd4) | ((idx_q == 3'd4) & disp_q[16]));
    an_d    = lit ? ~(8'b1 << idx_q) : 8'hFF;
    seg_d   = !lit ? 7'h7F : idx_q[2] ? HEX[1] : HEX[nib];
    dp_d    = 1'b1;
  end
  always_ff @(posedge Clk or negedge Rs) begin
    if (!Rs) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      disp_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      disp_q  <= disp_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end
  assign AN    = an_q;
  assign Seg   = seg_q;
  assign Dp    = dp_q;
  assign Valid = valid_q;
endmodule

// File: tb/tb_seg7_sum_scanner.sv
// tb_seg7_sum_scanner: directed checks of capture timing, scan order, recapture and async reset with REFRESH_DIV=4.
module tb_seg7_sum_scanner;
  logic        Clk = 1'b0;
  logic        Rs = 1'b0;
  logic [15:0] Sum = '0;
  logic        Cout = 1'b0;
  logic        Load = 1'b0;
  logic [7:0]  AN;
  logic [6:0]  Seg;
  logic        Dp;
  logic        Valid;
  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [7:0] an_a5 [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hFF, 8'hFF, 8'hFF};
  logic [6:0] seg_a5 [8] = '{7'h30, 7'h46, 7'h12, 7'h08, 7'h79, 7'h7F, 7'h7F, 7'h7F};
  logic [7:0] an_nc [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [6:0] seg_12 [8] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] seg_ff [8] = '{7'h0E, 7'h0E, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  seg7_sum_scanner #(.REFRESH_DIV(4)) dut (
    .Clk(Clk), .Rs(Rs), .Sum(Sum), .Cout(Cout), .Load(Load),
    .AN(AN), .Seg(Seg), .Dp(Dp), .Valid(Valid)
  );

  always #5 Clk = ~Clk;

  // clock edges since reset release; digit index after edge k is (k/4)%8
  always @(posedge Clk or negedge Rs)
    if (!Rs) n <= 0;
    else n <= n + 1;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rs = 1'b0;
    repeat (5) tick();
    checks += 4;
    if (AN !== 8'hFF) begin errors++; $display("FAIL reset_an got %h exp FF", AN); end
    if (Seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7F", Seg); end
    if (Dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", Dp); end
    if (Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", Valid); end
    Rs = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      checks++;
      if (AN !== 8'hFF || Valid !== 1'b0) begin
        errors++; $display("FAIL idle_blank n=%0d AN=%h Valid=%b exp FF 0", n, AN, Valid);
      end
    end
  endtask

  task automatic test_capture();
    Sum = 16'hA5C3; Cout = 1'b1; Load = 1'b1;
    tick();
    Load = 1'b0;
    checks++;
    if (Valid !== 1'b0) begin errors++; $display("FAIL lat_edge1 Valid=%b exp 0", Valid); end
    tick();
    checks++;
    if (Valid !== 1'b0) begin errors++; $display("FAIL lat_edge2 Valid=%b exp 0", Valid); end
    tick();
    checks += 2;
    if (Valid !== 1'b1) begin errors++; $display("FAIL lat_edge3 Valid=%b exp 1", Valid); end
    if (AN !== 8'hFF) begin errors++; $display("FAIL lat_an_edge3 AN=%h exp FF", AN); end
    for (int i = 0; i < 32; i++) begin
      int d;
      tick();
      d = ((n - 1) / 4) % 8;
      checks++;
      if (AN !== an_a5[d] || (an_a5[d] != 8'hFF && Seg !== seg_a5[d])) begin
        errors++; $display("FAIL scan_a5c3 n=%0d AN=%h Seg=%h exp AN=%h Seg=%h", n, AN, Seg, an_a5[d], seg_a5[d]);
      end
    end
  endtask

  task automatic test_single_capture();
    Load = 1'b1;
    repeat (3) tick();
    Sum = 16'h1234; Cout = 1'b0;
    for (int i = 0; i < 32; i++) begin
      int d;
      tick();
      d = ((n - 1) / 4) % 8;
      checks++;
      if (AN !== an_a5[d] || (an_a5[d] != 8'hFF && Seg !== seg_a5[d])) begin
        errors++; $display("FAIL held_load n=%0d AN=%h Seg=%h exp AN=%h Seg=%h", n, AN, Seg, an_a5[d], seg_a5[d]);
      end
    end
  endtask

  task automatic test_recapture();
    Load = 1'b0;
    repeat (3) tick();
    Load = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 32; i++) begin
      int d;
      tick();
      d = ((n - 1) / 4) % 8;
      checks++;
      if (AN !== an_nc[d] || (an_nc[d] != 8'hFF && Seg !== seg_12[d])) begin
        errors++; $display("FAIL scan_1234 n=%0d AN=%h Seg=%h exp AN=%h Seg=%h", n, AN, Seg, an_nc[d], seg_12[d]);
      end
    end
  endtask

  task automatic test_coincident();
    int old_d, new_d;
    bit found = 0;
    Load = 1'b0;
    Sum = 16'hA5C3; Cout = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 40 && !found; k++) begin
      if (n % 4 == 1 && ((n + 3) / 4) % 8 inside {[1:3]}) found = 1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL coinc_align no aligned slot within 40 cycles got n=%0d", n);
    end else begin
      Load = 1'b1;
      repeat (3) tick();
      old_d = ((n - 1) / 4) % 8;
      new_d = (n / 4) % 8;
      checks += 2;
      if (AN !== an_nc[old_d] || Seg !== seg_12[old_d]) begin
        errors++; $display("FAIL coinc_before AN=%h Seg=%h exp AN=%h Seg=%h", AN, Seg, an_nc[old_d], seg_12[old_d]);
      end
      if (Valid !== 1'b1) begin errors++; $display("FAIL coinc_valid got %b exp 1", Valid); end
      tick();
      checks++;
      if (AN !== an_a5[new_d] || Seg !== seg_a5[new_d]) begin
        errors++; $display("FAIL coinc_after AN=%h Seg=%h exp AN=%h Seg=%h", AN, Seg, an_a5[new_d], seg_a5[new_d]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      tick();
      if (AN === 8'hFB) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL mid_wait digit 2 never lit AN=%h exp FB", AN);
    end
    #2;
    Rs = 1'b0;
    #1;
    checks += 4;
    if (AN !== 8'hFF) begin errors++; $display("FAIL mid_async_an got %h exp FF", AN); end
    if (Seg !== 7'h7F) begin errors++; $display("FAIL mid_async_seg got %h exp 7F", Seg); end
    if (Valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b exp 0", Valid); end
    if (Dp !== 1'b1) begin errors++; $display("FAIL mid_async_dp got %b exp 1", Dp); end
    Sum = 16'h00FF; Cout = 1'b0;
    tick();
    Rs = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (AN !== 8'hFF || Valid !== (e == 3)) begin
        errors++; $display("FAIL post_reset_edge%0d AN=%h Valid=%b exp AN=FF Valid=%b", e, AN, Valid, e == 3);
      end
    end
    for (int i = 0; i < 32; i++) begin
      int d;
      tick();
      d = ((n - 1) / 4) % 8;
      checks++;
      if (AN !== an_nc[d] || (an_nc[d] != 8'hFF && Seg !== seg_ff[d])) begin
        errors++; $display("FAIL scan_00ff n=%0d AN=%h Seg=%h exp AN=%h Seg=%h", n, AN, Seg, an_nc[d], seg_ff[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_single_capture();
    test_recapture();
    test_coincident();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
